// File: rtl/serializer_pkg.sv
// Shared constants and types for the serializer unit cell.
// Optional build macro: SERIALIZER_LSB_FIRST_EN (shift each word LSB first).
package serializer_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int COUNT_W   = 6;
    localparam int SAMPLE_W  = 4;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Plain constants mirroring state_e, for the legacy-style state register
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/serializer_shift_word.sv
// One-word load/shift register with a bit-index counter and a last-bit flag.
// Optional build macro: SERIALIZER_LSB_FIRST_EN (shift right, present bit 0 first).
module serializer_shift_word
    import serializer_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load,
    input  logic               shift,
    input  logic               clear,
    input  word_t              load_data,
    output logic               serial_bit,
    output logic [COUNT_W-1:0] bit_count,
    output logic               last_bit
);

    word_t shreg;

    // Reset/clear zero the word, load restarts the count, shift advances one bit
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (load) begin
            shreg     <= load_data;
            bit_count <= '0;
        end else if (shift) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            shreg     <= {1'b0, shreg[WORD_W-1:1]};
`else
            shreg     <= {shreg[WORD_W-2:0], 1'b0};
`endif
            bit_count <= bit_count + COUNT_W'(1);
        end
    end

`ifdef SERIALIZER_LSB_FIRST_EN
    assign serial_bit = shreg[0];
`else
    assign serial_bit = shreg[WORD_W-1];
`endif

    assign last_bit = (bit_count == COUNT_W'(WORD_W - 1));

endmodule

// File: rtl/serializer_unit_cell.sv
// Parallel-to-serial converter: captures eight words, sends word 1 first.
// Optional build macro: SERIALIZER_LSB_FIRST_EN (each word sent LSB first).
module serializer_unit_cell
    import serializer_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                READY,
    input  logic [WORD_W-1:0]   PAR_IN1,
    input  logic [WORD_W-1:0]   PAR_IN2,
    input  logic [WORD_W-1:0]   PAR_IN3,
    input  logic [WORD_W-1:0]   PAR_IN4,
    input  logic [WORD_W-1:0]   PAR_IN5,
    input  logic [WORD_W-1:0]   PAR_IN6,
    input  logic [WORD_W-1:0]   PAR_IN7,
    input  logic [WORD_W-1:0]   PAR_IN8,
    output logic                SERIAL_OUT,
    output logic                INTERNAL_FINISH,
    output logic                COMPLETE,
    output logic [COUNT_W-1:0]  COUNT,
    output logic [SAMPLE_W-1:0] SAMPLE_COUNT
);

    logic [0:0]          state;
    logic [SAMPLE_W-1:0] sample_count;
    word_t               bank [NUM_WORDS];

    logic                last_bit;
    logic                frame_end;
    logic                capture;
    logic                word_wrap;
    logic                end_to_idle;
    logic                sw_load;
    logic                sw_shift;
    logic [IDX_W-1:0]    next_idx;
    word_t               sw_data;

    // The serial bit register doubles as SERIAL_OUT; word 1 is loaded straight
    // from PAR_IN1 so the first bit appears right after the capturing edge
    serializer_shift_word u_shift_word (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (sw_load),
        .shift      (sw_shift),
        .clear      (end_to_idle),
        .load_data  (sw_data),
        .serial_bit (SERIAL_OUT),
        .bit_count  (COUNT),
        .last_bit   (last_bit)
    );

    // Decode frame events: capture from idle or back-to-back, word wrap, drop to idle
    always_comb begin
        frame_end   = (state == ST_SHIFT) && last_bit &&
                      (sample_count == SAMPLE_W'(NUM_WORDS - 1));
        capture     = READY && ((state == ST_IDLE) || frame_end);
        word_wrap   = (state == ST_SHIFT) && last_bit && !frame_end;
        end_to_idle = frame_end && !READY;
        next_idx    = sample_count[IDX_W-1:0] + IDX_W'(1);
        sw_load     = capture || word_wrap;
        sw_shift    = (state == ST_SHIFT);
        sw_data     = capture ? PAR_IN1 : bank[next_idx];
    end

    // FSM, word counter and shadow bank; input words only sampled on capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            sample_count <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank[i] <= '0;
            end
        end else if (capture) begin
            state        <= ST_SHIFT;
            sample_count <= '0;
            bank[0]      <= PAR_IN1;
            bank[1]      <= PAR_IN2;
            bank[2]      <= PAR_IN3;
            bank[3]      <= PAR_IN4;
            bank[4]      <= PAR_IN5;
            bank[5]      <= PAR_IN6;
            bank[6]      <= PAR_IN7;
            bank[7]      <= PAR_IN8;
        end else if (frame_end) begin
            state        <= ST_IDLE;
            sample_count <= '0;
        end else if (word_wrap) begin
            sample_count <= sample_count + SAMPLE_W'(1);
        end
    end

    assign SAMPLE_COUNT    = sample_count;
    assign INTERNAL_FINISH = (state == ST_SHIFT) && last_bit;
    assign COMPLETE        = frame_end;

endmodule

// File: tb/tb_serializer_unit_cell.sv
// Directed self-checking bench for serializer_unit_cell.
// Honours SERIALIZER_LSB_FIRST_EN when building the expected bit order.
module tb_serializer_unit_cell;
    import serializer_pkg::*;

    logic                CLK;
    logic                RESET;
    logic                READY;
    logic [WORD_W-1:0]   PAR_IN1, PAR_IN2, PAR_IN3, PAR_IN4;
    logic [WORD_W-1:0]   PAR_IN5, PAR_IN6, PAR_IN7, PAR_IN8;
    logic                SERIAL_OUT;
    logic                INTERNAL_FINISH;
    logic                COMPLETE;
    logic [COUNT_W-1:0]  COUNT;
    logic [SAMPLE_W-1:0] SAMPLE_COUNT;

    int    checks = 0;
    int    errors = 0;
    word_t exp_words [NUM_WORDS];

    serializer_unit_cell dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .READY           (READY),
        .PAR_IN1         (PAR_IN1),
        .PAR_IN2         (PAR_IN2),
        .PAR_IN3         (PAR_IN3),
        .PAR_IN4         (PAR_IN4),
        .PAR_IN5         (PAR_IN5),
        .PAR_IN6         (PAR_IN6),
        .PAR_IN7         (PAR_IN7),
        .PAR_IN8         (PAR_IN8),
        .SERIAL_OUT      (SERIAL_OUT),
        .INTERNAL_FINISH (INTERNAL_FINISH),
        .COMPLETE        (COMPLETE),
        .COUNT           (COUNT),
        .SAMPLE_COUNT    (SAMPLE_COUNT)
    );

    // 100 MHz free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bit index within a word presented on position p of that word
    function automatic int bit_pos(input int p);
`ifdef SERIALIZER_LSB_FIRST_EN
        return p;
`else
        return 31 - p;
`endif
    endfunction

    // Expected {SERIAL_OUT, INTERNAL_FINISH, COMPLETE, COUNT, SAMPLE_COUNT} on SHIFT cycle n
    function automatic logic [12:0] exp_vec(input int n);
        int k = n / 32;
        int p = n % 32;
        return {exp_words[k][bit_pos(p)], (p == 31), (n == 255), 6'(p), 4'(k)};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {SERIAL_OUT, INTERNAL_FINISH, COMPLETE, COUNT, SAMPLE_COUNT};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_inputs(input word_t w [NUM_WORDS]);
        PAR_IN1 = w[0]; PAR_IN2 = w[1]; PAR_IN3 = w[2]; PAR_IN4 = w[3];
        PAR_IN5 = w[4]; PAR_IN6 = w[5]; PAR_IN7 = w[6]; PAR_IN8 = w[7];
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        READY = 1'b1;
        PAR_IN1 = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== 13'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected 0", i, obs_vec());
            end
        end
        RESET = 1'b0;
        READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== 13'd0) begin
                errors++;
                $display("[TB] FAIL reset_release cycle %0d: got %h expected 0", i, obs_vec());
            end
        end
    endtask

    task automatic test_single_frame();
        word_t      rx [NUM_WORDS];
        word_t      hand [NUM_WORDS];
        int         fin_cnt = 0;
        int         comp_cnt = 0;
        int         wraps = 0;
        logic [3:0] prev_sample = 4'd0;
        hand = '{32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h8FFF_FFFF, 32'h1FFF_FFFF,
                 32'd23456, 32'd12356, 32'd12456, 32'd1};
        exp_words = hand;
        set_inputs(hand);
        READY = 1'b1;
        tick();
        READY = 1'b0;
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (obs_vec() !== exp_vec(n)) begin
                errors++;
                $display("[TB] FAIL single_frame cycle %0d: got %h expected %h", n, obs_vec(), exp_vec(n));
            end
            rx[n / 32][bit_pos(n % 32)] = SERIAL_OUT;
            if (INTERNAL_FINISH === 1'b1) fin_cnt++;
            if (COMPLETE === 1'b1) comp_cnt++;
            if (SAMPLE_COUNT !== prev_sample && COUNT === 6'd0) wraps++;
            prev_sample = SAMPLE_COUNT;
            if (n < 255) tick();
        end
        for (int k = 0; k < NUM_WORDS; k++) begin
            checks++;
            if (rx[k] !== hand[k]) begin
                errors++;
                $display("[TB] FAIL rx_word%0d: got %h expected %h", k + 1, rx[k], hand[k]);
            end
        end
        checks++;
        if (fin_cnt != 8) begin
            errors++;
            $display("[TB] FAIL finish_pulses: got %0d expected 8", fin_cnt);
        end
        checks++;
        if (comp_cnt != 1) begin
            errors++;
            $display("[TB] FAIL complete_pulses: got %0d expected 1", comp_cnt);
        end
        checks++;
        if (wraps != 7) begin
            errors++;
            $display("[TB] FAIL sample_steps_on_wrap: got %0d expected 7", wraps);
        end
        tick();
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_frame: got %h expected 0", obs_vec());
        end
    endtask

    task automatic test_back_to_back();
        word_t first [NUM_WORDS];
        word_t second [NUM_WORDS];
        first  = '{32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h8FFF_FFFF, 32'h1FFF_FFFF,
                   32'd23456, 32'd12356, 32'd12456, 32'd1};
        second = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd23456, 32'd12356, 32'd12456, 32'd1};
        exp_words = first;
        set_inputs(first);
        READY = 1'b1;
        tick();
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (obs_vec() !== exp_vec(n)) begin
                errors++;
                $display("[TB] FAIL b2b_frame1 cycle %0d: got %h expected %h", n, obs_vec(), exp_vec(n));
            end
            if (n == 29) begin
                PAR_IN1 = 32'd2; PAR_IN2 = 32'd3; PAR_IN3 = 32'd4; PAR_IN4 = 32'd5;
            end
            tick();
        end
        READY = 1'b0;
        exp_words = second;
        for (int n = 0; n < 256; n++) begin
            checks++;
            if (obs_vec() !== exp_vec(n)) begin
                errors++;
                $display("[TB] FAIL b2b_frame2 cycle %0d: got %h expected %h", n, obs_vec(), exp_vec(n));
            end
            tick();
        end
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got %h expected 0", obs_vec());
        end
    endtask

    task automatic test_reset_mid_frame();
        word_t w [NUM_WORDS];
        w = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0, 32'hFFFF_0000,
              32'h0F0F_0F0F, 32'h8000_0001, 32'h7FFF_FFFE, 32'hDEAD_BEEF};
        exp_words = w;
        set_inputs(w);
        READY = 1'b1;
        tick();
        READY = 1'b0;
        for (int n = 0; n <= 100; n++) begin
            checks++;
            if (obs_vec() !== exp_vec(n)) begin
                errors++;
                $display("[TB] FAIL pre_reset cycle %0d: got %h expected %h", n, obs_vec(), exp_vec(n));
            end
            if (n < 100) tick();
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++;
            $display("[TB] FAIL mid_frame_reset: got %h expected 0", obs_vec());
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++;
            $display("[TB] FAIL after_reset_idle: got %h expected 0", obs_vec());
        end
        w = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_FFFF, 32'h1,
              32'h2, 32'h3, 32'h4, 32'h5};
        exp_words = w;
        set_inputs(w);
        READY = 1'b1;
        tick();
        READY = 1'b0;
        for (int n = 0; n < 40; n++) begin
            checks++;
            if (obs_vec() !== exp_vec(n)) begin
                errors++;
                $display("[TB] FAIL restart cycle %0d: got %h expected %h", n, obs_vec(), exp_vec(n));
            end
            tick();
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if (obs_vec() !== 13'd0) begin
            errors++;
            $display("[TB] FAIL final_reset: got %h expected 0", obs_vec());
        end
    endtask

    // Scenario sequence
    initial begin
        RESET = 1'b1;
        READY = 1'b0;
        PAR_IN1 = '0; PAR_IN2 = '0; PAR_IN3 = '0; PAR_IN4 = '0;
        PAR_IN5 = '0; PAR_IN6 = '0; PAR_IN7 = '0; PAR_IN8 = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serializer_unit_cell.md
Name: serializer_unit_cell

Overview:
Parallel-to-serial converter. It captures eight 32-bit words in one cycle and shifts them out one bit per clock on a single serial line: word 1 first, MSB first. It reports per-word and per-frame completion and exposes its bit and word counters for debug and monitoring. It sits between the parallel datapath and the serial link driver.

Parameters:
WORD_W, 32, bits per word
NUM_WORDS, 8, words per frame
COUNT_W, 6, width of the bit-index counter output
SAMPLE_W, 4, width of the word-index counter output

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
READY  input  1  frame request; sampled when idle or on the final bit of a frame
PAR_IN1..PAR_IN8  input  32 each  parallel words; PAR_IN1 is sent first
SERIAL_OUT  output  1  registered serial data
INTERNAL_FINISH  output  1  high while the last bit of any word is presented
COMPLETE  output  1  high while the last bit of the frame is presented
COUNT  output  6  index of the bit currently presented within its word (0..31)
SAMPLE_COUNT  output  4  index of the word currently presented (0..7)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (RESET=1 at a rising edge):
  - state goes to IDLE;
  - SERIAL_OUT, INTERNAL_FINISH, COMPLETE, COUNT and SAMPLE_COUNT all go to 0;
  - shadow registers are cleared.
- Reset has priority over every other event, including mid-frame. A frame interrupted by reset is abandoned and is not resumed.
- States: IDLE and SHIFT.
- IDLE:
  - all outputs are 0;
  - if READY=1 at an edge, all eight PAR_IN words are captured into shadow registers and the state goes to SHIFT.
- SHIFT:
  - Presentation order: the first SHIFT cycle presents word 1 bit 31, with COUNT=0 and SAMPLE_COUNT=0.
  - Each following cycle presents the next lower bit.
  - In general, word k (0-based) bit j appears on SHIFT cycle 32k+(31−j), with COUNT=31−j and SAMPLE_COUNT=k.
  - Latency: the first serial bit appears one cycle after the capturing edge.
- PAR_IN is ignored while in SHIFT. Changes to PAR_IN mid-frame have no effect until the next capture.
- INTERNAL_FINISH is asserted when COUNT=31. This gives one single-cycle pulse per word, 8 per frame.
- COMPLETE is asserted when COUNT=31 and SAMPLE_COUNT=7. It is coincident with the eighth INTERNAL_FINISH.
- Word wrap: COUNT goes 31 → 0 and SAMPLE_COUNT increments.
- End of frame, at the edge that ends the COMPLETE cycle:
  - if READY=1, new PAR_IN words are captured and the next cycle presents the new word 1 bit 31 (back-to-back frames, no gap);
  - otherwise the block returns to IDLE.
- READY falling mid-frame does not abort the frame.
- A frame is exactly 256 SHIFT cycles.

Optional Feature:
- Macro: SERIALIZER_LSB_FIRST_EN.
- When defined, each word is shifted LSB first: word k bit j appears on SHIFT cycle 32k+j, with COUNT=j.
- Word order, flags, counters and timing are unchanged.
- When undefined, words are shifted MSB first as specified above.

Decomposition:
- Package serializer_pkg holds:
  - the WORD_W, NUM_WORDS, COUNT_W and SAMPLE_W constants;
  - the state enum {IDLE, SHIFT};
  - the typedef word_t of 32-bit logic.
- One natural sub-module: serializer_shift_word. It is a 32-bit load/shift register with a bit counter and a last-bit flag.
- The top level holds the word bank, the word counter, the FSM and the flags.

Test Plan:
- Reset: hold RESET=1 for 3 cycles with READY=1 → all outputs 0 and state IDLE. After release with READY=0 → outputs stay 0.
- Single frame: READY=1 with PAR_IN1=0xFFFFFFFF, PAR_IN2=0x3FFFFFFF, PAR_IN3=0x8FFFFFFF, PAR_IN4=0x1FFFFFFF, PAR_IN5=23456, PAR_IN6=12356, PAR_IN7=12456, PAR_IN8=1 → required response:
  - 256-bit stream matches the words MSB first;
  - word 1 is 32 ones;
  - word 2 is 0,0 followed by 30 ones;
  - word 3 is 1,0,0,0 followed by 28 ones;
  - word 8 is 31 zeros followed by 1;
  - INTERNAL_FINISH pulses at SHIFT cycles 31, 63, …, 255;
  - COMPLETE pulses only at cycle 255.
- Mid-frame input change: at SHIFT cycle 29, set PAR_IN1..4 to 2, 3, 4, 5 → the current frame is unaffected; the next frame (READY held 1) starts with no gap and carries 2, 3, 4, 5 in words 1..4.
- Idle after frame: drop READY during the frame → the frame finishes all 256 bits, the block enters IDLE, and outputs are 0 the cycle after COMPLETE.
- Reset mid-frame: assert RESET at SHIFT cycle 100 → the next cycle has all outputs 0. A new READY restarts at word 1 bit 31, COUNT=0.
- Counter check: across one frame, COUNT cycles 0..31 eight times and SAMPLE_COUNT steps 0..7, each step aligned with COUNT wrap.
